// File: rtl/bus_mux_pkg.sv
// Shared defaults for the bus_mux lane selector.
package bus_mux_pkg;
  localparam int BUS_MUX_DEF_BITS_ENABLES = 1;
  localparam int BUS_MUX_DEF_BUS_SIZE     = 32;
endpackage

// File: rtl/bus_mux_reg.sv
// BUS_SIZE-wide output register, synchronous active-high reset to zero.
module bus_mux_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // Reset wins over capture of the incoming lane.
  always_comb begin
    data_d = rst ? '0 : i_d;
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign o_q = data_q;

endmodule

// File: rtl/bus_mux.sv
// Packed-lane bus multiplexer; out-of-range selects give zero.
// Define BUS_MUX_OUT_REG_EN to register o_data (1-cycle latency), else combinational.
module bus_mux
  import bus_mux_pkg::*;
#(
  parameter int BITS_ENABLES = BUS_MUX_DEF_BITS_ENABLES,
  parameter int BUS_SIZE     = BUS_MUX_DEF_BUS_SIZE,
  parameter int NUM_INPUTS   = 2 ** BITS_ENABLES
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [BITS_ENABLES-1:0]        i_en,
  input  logic [NUM_INPUTS*BUS_SIZE-1:0] i_data,
  output logic [BUS_SIZE-1:0]            o_data
);

  // No handshake: o_data is valid every cycle, there is no valid/ready pair.
  logic [BUS_SIZE-1:0] sel_data;

  // Only populated lanes can match, so unpopulated select codes fall through to zero.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (i_en == BITS_ENABLES'(k)) begin
        sel_data = i_data[k*BUS_SIZE +: BUS_SIZE];
      end
    end
  end

`ifdef BUS_MUX_OUT_REG_EN
  bus_mux_reg #(
    .WIDTH (BUS_SIZE)
  ) u_out_reg (
    .clk (clk),
    .rst (rst),
    .i_d (sel_data),
    .o_q (o_data)
  );
`else
  // Clock and reset are only consumed by the registered variant.
  wire unused_clk_rst = &{1'b0, clk, rst};
  assign o_data = sel_data;
`endif

endmodule

// File: tb/tb_bus_mux.sv
// Self-checking bench for bus_mux: directed literal cases plus randomized lanes/selects/reset.
module tb_bus_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:0]  en_a;
  logic [63:0] data_a;
  logic [31:0] out_a;
  logic [1:0]  en_b;
  logic [95:0] data_b;
  logic [31:0] out_b;

  int tests_run = 0;
  int tests_failed = 0;
  bit cmp_on = 1'b0;

  logic [31:0] exp_a_q[$];
  logic [31:0] exp_b_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  bus_mux dut_a (
    .clk    (clk),
    .rst    (rst),
    .i_en   (en_a),
    .i_data (data_a),
    .o_data (out_a)
  );

  bus_mux #(
    .BITS_ENABLES (2),
    .BUS_SIZE     (32),
    .NUM_INPUTS   (3)
  ) dut_b (
    .clk    (clk),
    .rst    (rst),
    .i_en   (en_b),
    .i_data (data_b),
    .o_data (out_b)
  );

  // Reference: lane 'en' of the flattened lanes, zero when no such lane exists.
  function automatic logic [31:0] pick(input logic [127:0] flat, input int num, input int en);
    if (en >= num) return 32'h0;
    return flat[en*32 +: 32];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_random();
    en_a   = 1'($urandom_range(0, 1));
    en_b   = 2'($urandom_range(0, 3));
    data_a = {$urandom(), $urandom()};
    data_b = {$urandom(), $urandom(), $urandom()};
    rst    = ($urandom_range(0, 9) == 0);
  endtask

`ifdef BUS_MUX_OUT_REG_EN
  // scoreboard: expected value captured at each edge from the inputs it samples
  always @(posedge clk) begin
    if (cmp_on) begin
      exp_a_q.push_back(rst ? 32'h0 : pick({64'h0, data_a}, 2, int'(en_a)));
      exp_b_q.push_back(rst ? 32'h0 : pick({32'h0, data_b}, 3, int'(en_b)));
    end
  end

  always @(negedge clk) begin
    if (cmp_on && exp_a_q.size() > 0 && exp_b_q.size() > 0) begin
      check("rand_a", out_a, exp_a_q.pop_front());
      check("rand_b", out_b, exp_b_q.pop_front());
    end
  end
`else
  always @(negedge clk) begin
    if (cmp_on) begin
      check("rand_a", out_a, pick({64'h0, data_a}, 2, int'(en_a)));
      check("rand_b", out_b, pick({32'h0, data_b}, 3, int'(en_b)));
    end
  end
`endif

  initial begin
    logic [31:0] steps [3];
    steps[0] = 32'h1;
    steps[1] = 32'h2;
    steps[2] = 32'hFFFF_FFFF;

    rst    = 1'b1;
    en_a   = 1'b0;
    en_b   = 2'd0;
    data_a = {32'h0, 32'h7};
    data_b = '0;
    repeat (2) @(posedge clk);
    #1;
`ifdef BUS_MUX_OUT_REG_EN
    check("reset_a", out_a, 32'h0);
    check("reset_b", out_b, 32'h0);
    en_a   = 1'b1;
    data_a = {32'hA5A5_A5A5, 32'h0000_0001};
    en_b   = 2'd2;
    data_b = {32'h33, 32'h22, 32'h11};
    rst    = 1'b0;
    @(posedge clk); #1;
    check("first_after_rst", out_a, 32'hA5A5_A5A5);
    check("reg_b_lane2", out_b, 32'h33);
    en_b = 2'd3;
    rst  = 1'b1;
    @(posedge clk); #1;
    check("mid_reset_a", out_a, 32'h0);
    check("mid_reset_b", out_b, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("release_a", out_a, 32'hA5A5_A5A5);
    check("oor_reg_b", out_b, 32'h0);
    en_b = 2'd1;
    @(posedge clk); #1;
    check("reg_b_lane1", out_b, 32'h22);
`else
    check("reset_no_effect", out_a, 32'h7);
    rst    = 1'b0;
    data_a = {32'hDEAD_BEEF, 32'h0000_0005};
    en_a   = 1'b0;
    #1 check("lane0", out_a, 32'h0000_0005);
    en_a = 1'b1;
    #1 check("lane1", out_a, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      data_a[63:32] = steps[i];
      #1 check("follow_upper", out_a, steps[i]);
      rst = ~rst;
      @(posedge clk); #1;
      check("rst_toggle", out_a, steps[i]);
    end
    rst    = 1'b0;
    data_b = {32'h33, 32'h22, 32'h11};
    en_b   = 2'd0;
    #1 check("b_lane0", out_b, 32'h11);
    en_b = 2'd1;
    #1 check("b_lane1", out_b, 32'h22);
    en_b = 2'd2;
    #1 check("b_lane2", out_b, 32'h33);
    en_b = 2'd3;
    #1 check("b_oor", out_b, 32'h0);
`endif

    @(posedge clk); #1;
    cmp_on = 1'b1;
    for (int c = 0; c < 400; c++) begin
      drive_random();
      @(posedge clk); #1;
    end
    cmp_on = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
